// File: rtl/alux_seq_if.sv
// Command, host register-file, ALU handshake and status signals of the alux_seq sequencer.
// The sequencer takes the slave modport; the host/ALU environment takes the master modport.
interface alux_seq_if #(
   parameter int unsigned AW = 3
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [3:0]    cmd_opr;
   logic [AW-1:0] cmd_srca;
   logic [AW-1:0] cmd_srcb;
   logic [AW-1:0] cmd_dst;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [63:0]   wr_data;
   logic [AW-1:0] rd_addr;
   logic [63:0]   rd_data;
   logic          alu_start;
   logic [3:0]    alu_opr;
   logic [63:0]   alu_inA;
   logic [63:0]   alu_inB;
   logic [63:0]   alu_outAB;
   logic          alu_done;
   logic          busy;
   logic          err_clr;
   logic          err_timeout;
   logic [15:0]   op_count;

   modport master (
      output cmd_valid, cmd_opr, cmd_srca, cmd_srcb, cmd_dst,
      output wr_en, wr_addr, wr_data, rd_addr,
      output alu_outAB, alu_done, err_clr,
      input  cmd_ready, rd_data, alu_start, alu_opr, alu_inA, alu_inB,
      input  busy, err_timeout, op_count
   );

   modport slave (
      input  cmd_valid, cmd_opr, cmd_srca, cmd_srcb, cmd_dst,
      input  wr_en, wr_addr, wr_data, rd_addr,
      input  alu_outAB, alu_done, err_clr,
      output cmd_ready, rd_data, alu_start, alu_opr, alu_inA, alu_inB,
      output busy, err_timeout, op_count
   );
endinterface

// File: rtl/alux_seq.sv
// Register-file command sequencer driving the complex ALU start/opr/done handshake.
// Optional completed-command counter enabled by defining ALUXSEQ_STATS_EN.
module alux_seq #(
   parameter int unsigned NREG    = 8,
   parameter int unsigned AW      = 3,
   parameter int unsigned TIMEOUT = 64
) (
   input logic       clock,
   input logic       reset,
   alux_seq_if.slave bus
);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StWb} state_e;

   state_e        state;
   logic [3:0]    opr;
   logic [AW-1:0] srca;
   logic [AW-1:0] srcb;
   logic [AW-1:0] dst;
   logic [CW-1:0] cnt;
   logic          start;
   logic [3:0]    opr_out;
   logic [63:0]   in_a;
   logic [63:0]   in_b;
   logic          err;
   logic [63:0]   rf [NREG];

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= StIdle;
         opr     <= '0;
         srca    <= '0;
         srcb    <= '0;
         dst     <= '0;
         cnt     <= '0;
         start   <= 1'b0;
         opr_out <= '0;
         in_a    <= '0;
         in_b    <= '0;
         err     <= 1'b0;
         for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
      end else begin
         if (bus.err_clr) err <= 1'b0;
         // Host port first so the writeback below overrides it on an address clash.
         if (bus.wr_en) rf[bus.wr_addr] <= bus.wr_data;
         case (state)
            StIdle: begin
               if (bus.cmd_valid) begin
                  opr   <= bus.cmd_opr;
                  srca  <= bus.cmd_srca;
                  srcb  <= bus.cmd_srcb;
                  dst   <= bus.cmd_dst;
                  state <= StIssue;
               end
            end
            StIssue: begin
               in_a    <= rf[srca];
               in_b    <= rf[srcb];
               opr_out <= opr;
               start   <= 1'b1;
               cnt     <= '0;
               state   <= StWait;
            end
            StWait: begin
               if (bus.alu_done) begin
                  state <= StWb;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  start <= 1'b0;
                  state <= StIdle;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StWb: begin
               // The ALU presents its result one cycle after done.
               rf[dst] <= bus.alu_outAB;
               start   <= 1'b0;
               state   <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign bus.cmd_ready   = (state == StIdle);
   assign bus.busy        = (state != StIdle);
   assign bus.rd_data     = rf[bus.rd_addr];
   assign bus.alu_start   = start;
   assign bus.alu_opr     = opr_out;
   assign bus.alu_inA     = in_a;
   assign bus.alu_inB     = in_b;
   assign bus.err_timeout = err;

`ifdef ALUXSEQ_STATS_EN
   logic [15:0] count;

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (state == StWb && count != 16'hFFFF) begin
         count <= count + 16'd1;
      end
   end

   assign bus.op_count = count;
`else
   assign bus.op_count = '0;
`endif
endmodule

// File: tb/tb_alux_seq.sv
// Directed self-checking bench for alux_seq; the bench plays both host and ALU.
module tb_alux_seq;
   logic clock = 1'b0;
   logic reset;
   always #10 clock = ~clock;

   alux_seq_if #(.AW(3)) bus ();

   alux_seq #(.NREG(8), .AW(3), .TIMEOUT(64)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] R1   = 64'h00000003_00000004;
   localparam logic [63:0] R2   = 64'h00000001_00000002;
   localparam logic [63:0] JUNK = 64'hBAD0BAD0_BAD0BAD0;
`ifdef ALUXSEQ_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   function automatic logic [63:0] alu_model(input logic [3:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
      case (op)
         4'b0000: return a;
         4'b0001: return b;
         4'b0010: return {a[63:32] + b[63:32], a[31:0] + b[31:0]};
         default: return '0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic read_reg(input logic [2:0] a, output logic [63:0] v);
      bus.rd_addr = a;
      #1;
      v = bus.rd_data;
   endtask

   task automatic host_write(input logic [2:0] a, input logic [63:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   // Returns just after the accepting edge (sequencer in ISSUE).
   task automatic accept(input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb,
                         input logic [2:0] d);
      int n = 0;
      bus.cmd_opr   = op;
      bus.cmd_srca  = sa;
      bus.cmd_srcb  = sb;
      bus.cmd_dst   = d;
      bus.cmd_valid = 1'b1;
      while (bus.cmd_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_wait: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, n);
      end
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   // ALU side of one command, entered in ISSUE; optional host write during the WB cycle.
   task automatic serve(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int delay, input logic hen, input logic [2:0] haddr,
                        input logic [63:0] hdata);
      logic [63:0] res;
      res = alu_model(op, a, b);
      checks++;
      if (bus.alu_start !== 1'b0 || bus.cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL issue_state: alu_start=%b cmd_ready=%b, required 0 0",
                  bus.alu_start, bus.cmd_ready);
      end
      tick();
      checks++;
      if (bus.alu_start !== 1'b1 || bus.alu_opr !== op || bus.alu_inA !== a || bus.alu_inB !== b)
      begin
         errors++;
         $display("FAIL issue_regs: start=%b opr=%h A=%h B=%h, required 1 %h %h %h",
                  bus.alu_start, bus.alu_opr, bus.alu_inA, bus.alu_inB, op, a, b);
      end
      for (int i = 0; i < delay; i++) begin
         tick();
         checks++;
         if (bus.alu_start !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1 ||
             bus.alu_inA !== a || bus.alu_inB !== b) begin
            errors++;
            $display("FAIL wait_hold: start=%b ready=%b busy=%b A=%h B=%h, required 1 0 1 %h %h",
                     bus.alu_start, bus.cmd_ready, bus.busy, bus.alu_inA, bus.alu_inB, a, b);
         end
      end
      bus.alu_done  = 1'b1;
      bus.alu_outAB = JUNK;
      tick();
      bus.alu_done  = 1'b0;
      bus.alu_outAB = res;
      if (hen) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = haddr;
         bus.wr_data = hdata;
      end
      checks++;
      if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL wb_state: cmd_ready=%b busy=%b, required 0 1", bus.cmd_ready, bus.busy);
      end
      tick();
      bus.wr_en = 1'b0;
      checks++;
      if (bus.cmd_ready !== 1'b1 || bus.alu_start !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL wb_done: cmd_ready=%b alu_start=%b busy=%b, required 1 0 0",
                  bus.cmd_ready, bus.alu_start, bus.busy);
      end
   endtask

   task automatic test_reset();
      logic [63:0] v;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      checks++;
      if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.alu_start !== 1'b0 ||
          bus.err_timeout !== 1'b0 || bus.op_count !== 16'd0 || bus.alu_inA !== 64'd0 ||
          bus.alu_inB !== 64'd0 || bus.alu_opr !== 4'd0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b busy=%b start=%b err=%b cnt=%h A=%h B=%h opr=%h",
                  bus.cmd_ready, bus.busy, bus.alu_start, bus.err_timeout, bus.op_count,
                  bus.alu_inA, bus.alu_inB, bus.alu_opr);
      end
      for (int i = 0; i < 8; i++) begin
         read_reg(3'(i), v);
         checks++;
         if (v !== 64'd0) begin
            errors++;
            $display("FAIL reset_rf: r%0d=%h, required 0", i, v);
         end
      end
   endtask

   task automatic test_basic();
      logic [63:0] v;
      host_write(3'd1, R1);
      host_write(3'd2, R2);
      read_reg(3'd1, v);
      checks++;
      if (v !== R1) begin
         errors++;
         $display("FAIL host_write_r1: got %h, required %h", v, R1);
      end
      accept(4'b0010, 3'd1, 3'd2, 3'd3);
      serve(4'b0010, R1, R2, 3, 1'b0, 3'd0, 64'd0);
      read_reg(3'd3, v);
      checks++;
      if (v !== 64'h00000004_00000006) begin
         errors++;
         $display("FAIL basic_add_r3: got %h, required %h", v, 64'h00000004_00000006);
      end
      checks++;
      if (bus.op_count !== (STATS ? 16'd1 : 16'd0)) begin
         errors++;
         $display("FAIL op_count_basic: got %0d, required %0d", bus.op_count, STATS ? 1 : 0);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] v;
      bus.cmd_opr   = 4'b0000;
      bus.cmd_srca  = 3'd1;
      bus.cmd_srcb  = 3'd1;
      bus.cmd_dst   = 3'd4;
      bus.cmd_valid = 1'b1;
      tick();
      // Second command presented immediately while the first is in flight.
      bus.cmd_opr   = 4'b0001;
      bus.cmd_srca  = 3'd1;
      bus.cmd_srcb  = 3'd2;
      bus.cmd_dst   = 3'd5;
      serve(4'b0000, R1, R1, 2, 1'b0, 3'd0, 64'd0);
      read_reg(3'd4, v);
      checks++;
      if (v !== R1) begin
         errors++;
         $display("FAIL b2b_r4: got %h, required %h", v, R1);
      end
      tick();
      bus.cmd_valid = 1'b0;
      serve(4'b0001, R1, R2, 1, 1'b0, 3'd0, 64'd0);
      read_reg(3'd5, v);
      checks++;
      if (v !== R2) begin
         errors++;
         $display("FAIL b2b_r5: got %h, required %h", v, R2);
      end
   endtask

   task automatic test_wb_collision();
      logic [63:0] v;
      accept(4'b0000, 3'd1, 3'd1, 3'd3);
      serve(4'b0000, R1, R1, 0, 1'b1, 3'd3, 64'hDEAD);
      read_reg(3'd3, v);
      checks++;
      if (v !== R1) begin
         errors++;
         $display("FAIL wb_wins_r3: got %h, required %h", v, R1);
      end
      accept(4'b0001, 3'd1, 3'd2, 3'd3);
      serve(4'b0001, R1, R2, 1, 1'b1, 3'd6, 64'hDEAD);
      read_reg(3'd3, v);
      checks++;
      if (v !== R2) begin
         errors++;
         $display("FAIL dual_write_r3: got %h, required %h", v, R2);
      end
      read_reg(3'd6, v);
      checks++;
      if (v !== 64'hDEAD) begin
         errors++;
         $display("FAIL dual_write_r6: got %h, required %h", v, 64'hDEAD);
      end
   endtask

   task automatic test_chain();
      logic [63:0] v;
      accept(4'b0010, 3'd3, 3'd3, 3'd0);
      serve(4'b0010, R2, R2, 2, 1'b0, 3'd0, 64'd0);
      read_reg(3'd0, v);
      checks++;
      if (v !== 64'h00000002_00000004) begin
         errors++;
         $display("FAIL chain_r0: got %h, required %h", v, 64'h00000002_00000004);
      end
   endtask

   task automatic test_timeout();
      logic [63:0] v;
      accept(4'b0010, 3'd1, 3'd2, 3'd7);
      tick();
      repeat (63) tick();
      checks++;
      if (bus.err_timeout !== 1'b0 || bus.busy !== 1'b1 || bus.alu_start !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early: err=%b busy=%b start=%b, required 0 1 1",
                  bus.err_timeout, bus.busy, bus.alu_start);
      end
      tick();
      checks++;
      if (bus.err_timeout !== 1'b1 || bus.cmd_ready !== 1'b1 || bus.alu_start !== 1'b0) begin
         errors++;
         $display("FAIL timeout_fire: err=%b ready=%b start=%b, required 1 1 0",
                  bus.err_timeout, bus.cmd_ready, bus.alu_start);
      end
      read_reg(3'd7, v);
      checks++;
      if (v !== 64'd0) begin
         errors++;
         $display("FAIL timeout_no_wb: r7=%h, required 0", v);
      end
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      checks++;
      if (bus.err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL err_clr: err=%b, required 0", bus.err_timeout);
      end
      // err_clr held across a second timeout: set must win on the timeout edge.
      bus.err_clr = 1'b1;
      accept(4'b0010, 3'd1, 3'd2, 3'd7);
      tick();
      repeat (63) tick();
      checks++;
      if (bus.err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL clr_held: err=%b, required 0", bus.err_timeout);
      end
      tick();
      bus.err_clr = 1'b0;
      checks++;
      if (bus.err_timeout !== 1'b1) begin
         errors++;
         $display("FAIL set_wins: err=%b, required 1", bus.err_timeout);
      end
      tick();
      checks++;
      if (bus.err_timeout !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: err=%b, required 1", bus.err_timeout);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] v;
      accept(4'b0010, 3'd1, 3'd2, 3'd3);
      repeat (3) tick();
      checks++;
      if (bus.busy !== 1'b1 || bus.alu_start !== 1'b1) begin
         errors++;
         $display("FAIL mid_wait: busy=%b start=%b, required 1 1", bus.busy, bus.alu_start);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (bus.alu_start !== 1'b0 || bus.busy !== 1'b0 || bus.err_timeout !== 1'b0 ||
          bus.alu_inA !== 64'd0 || bus.alu_opr !== 4'd0 || bus.op_count !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset: start=%b busy=%b err=%b A=%h opr=%h cnt=%h, required 0 0 0 0 0 0",
                  bus.alu_start, bus.busy, bus.err_timeout, bus.alu_inA, bus.alu_opr,
                  bus.op_count);
      end
      for (int i = 0; i < 8; i++) begin
         read_reg(3'(i), v);
         checks++;
         if (v !== 64'd0) begin
            errors++;
            $display("FAIL mid_reset_rf: r%0d=%h, required 0", i, v);
         end
      end
      reset         = 1'b0;
      bus.alu_done  = 1'b1;
      bus.alu_outAB = R1;
      tick();
      bus.alu_done  = 1'b0;
      tick();
      read_reg(3'd3, v);
      checks++;
      if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || v !== 64'd0) begin
         errors++;
         $display("FAIL late_done: busy=%b ready=%b r3=%h, required 0 1 0",
                  bus.busy, bus.cmd_ready, v);
      end
   endtask

   task automatic test_stats();
      host_write(3'd1, R1);
      host_write(3'd2, R2);
      accept(4'b0000, 3'd1, 3'd2, 3'd4);
      serve(4'b0000, R1, R2, 0, 1'b0, 3'd0, 64'd0);
      accept(4'b0001, 3'd1, 3'd2, 3'd5);
      serve(4'b0001, R1, R2, 1, 1'b0, 3'd0, 64'd0);
      accept(4'b0010, 3'd1, 3'd2, 3'd6);
      serve(4'b0010, R1, R2, 2, 1'b0, 3'd0, 64'd0);
      accept(4'b0010, 3'd1, 3'd2, 3'd7);
      tick();
      repeat (64) tick();
      checks++;
      if (bus.err_timeout !== 1'b1 || bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL stats_timeout: err=%b ready=%b, required 1 1",
                  bus.err_timeout, bus.cmd_ready);
      end
      checks++;
      if (bus.op_count !== (STATS ? 16'd3 : 16'd0)) begin
         errors++;
         $display("FAIL op_count: got %0d, required %0d", bus.op_count, STATS ? 3 : 0);
      end
   endtask

   initial begin
      reset         = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_opr   = '0;
      bus.cmd_srca  = '0;
      bus.cmd_srcb  = '0;
      bus.cmd_dst   = '0;
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.rd_addr   = '0;
      bus.alu_outAB = '0;
      bus.alu_done  = 1'b0;
      bus.err_clr   = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_wb_collision();
      test_chain();
      test_timeout();
      test_reset_mid();
      test_stats();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/alux_seq.md
Name: alux_seq

Overview:
Command sequencer and initiator for the complex-number ALU's start/opr/done handshake. It holds a small register file of 64-bit complex operands, with {real[63:32], imag[31:0]}. It accepts register-addressed commands from a host, drives the ALU's operands, opcode and start, waits for done, and writes the ALU result back to the destination register. This lets a host chain complex operations without handling the ALU handshake itself.

Parameters:
NREG, 8, number of 64-bit registers in the file
AW, 3, register address width; must satisfy 2**AW == NREG
TIMEOUT, 64, maximum number of WAIT cycles for alu_done before the command is aborted

Ports:
clock  in  1  master clock, posedge
reset  in  1  synchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  sequencer can accept a command
cmd_opr  in  4  ALU opcode, passed through unchanged
cmd_srca  in  AW  register address of operand A
cmd_srcb  in  AW  register address of operand B
cmd_dst  in  AW  destination register address
wr_en  in  1  host register write strobe
wr_addr  in  AW  host write address
wr_data  in  64  host write data
rd_addr  in  AW  host read address
rd_data  out  64  combinational read of rf[rd_addr]
alu_start  out  1  ALU start, registered
alu_opr  out  4  ALU opcode, registered
alu_inA  out  64  operand A, registered
alu_inB  out  64  operand B, registered
alu_outAB  in  64  ALU result
alu_done  in  1  ALU completion
busy  out  1  high in any state other than IDLE
err_clr  in  1  clears err_timeout
err_timeout  out  1  sticky flag: a command was aborted on timeout
op_count  out  16  completed-command counter (see Optional Feature)

Behaviour:
- Reset values: every register = 0, state = IDLE, alu_start/alu_opr/alu_inA/alu_inB = 0, err_timeout = 0, op_count = 0.
- Reset mid-operation: on the next edge, return to IDLE and drop alu_start; no writeback occurs.
- FSM states: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch opr/srca/srcb/dst and go to ISSUE.
- ISSUE:
  - Register alu_inA = rf[srca], alu_inB = rf[srcb], alu_opr = opr, alu_start = 1.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - alu_start and the operand/opcode outputs are held stable.
  - Counter increments each cycle.
  - alu_done = 1: go to WB.
  - Counter reaches TIMEOUT-1 without done: set err_timeout, drop alu_start, skip writeback, go to IDLE.
- WB:
  - The ALU registers outAB one cycle after it raises done, so alu_outAB is sampled in WB.
  - rf[dst] <= alu_outAB, alu_start <= 0, go to IDLE.
- Latency: accept at edge 0, alu_start high after edge 1, first done seen at edge k, writeback at edge k+1, cmd_ready high again after edge k+1.
- cmd_ready = 0 in ISSUE, WAIT and WB. A held cmd_valid is accepted only on return to IDLE; one command is in flight at a time.
- The register file has two write ports, host and WB:
  - Same address, same cycle: WB wins and the host write is dropped.
  - Different addresses: both writes take effect.
- Operands are read in ISSUE from the current file contents, so a command that uses the previous command's dst sees the written value.
- err_clr clears err_timeout. A timeout and err_clr in the same cycle: set wins.
- alu_outAB is 64-bit opaque; no arithmetic is done locally.

Optional Feature:
ALUXSEQ_STATS_EN:
- Defined: op_count increments by 1 on every WB and saturates at 16'hFFFF. Timeouts do not count. Cleared only by reset.
- Undefined: op_count is tied to 0 and no counter logic is generated. The port is always present.

Test Plan:
- Host writes r1=64'h00000003_00000004 and r2=64'h00000001_00000002, then cmd opr=4'b0010 (A+B), srca=1, srcb=2, dst=3 -> alu_start rises 1 cycle after accept, rf[3]=64'h00000004_00000006 written one cycle after done, cmd_ready returns high.
- Two commands back-to-back with cmd_valid held: opr=0000 src=1 dst=4, then opr=0001 srcb=2 dst=5 -> second accepted only after the first WB; rf[4]=r1, rf[5]=r2; alu_start never high in IDLE.
- ALU model never asserts done, TIMEOUT=64 -> err_timeout=1 after 64 WAIT cycles, rf[dst] unchanged, cmd_ready=1; then err_clr -> err_timeout=0.
- Assert reset during WAIT -> next cycle alu_start=0, busy=0, all registers = 0; the late done is ignored.
- Host wr_en to dst=3 with wr_data=64'hDEAD in the WB cycle -> rf[3] holds the ALU result. The same stimulus with wr_addr=6 -> both writes land.
- With ALUXSEQ_STATS_EN: 3 completed commands plus 1 timeout -> op_count=3. Without the macro: op_count=0 throughout.
